// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between an instruction-fetch port (port 0)
//   and a data load/store port (port 1). One access is in flight at a time;
//   the FSM walks IDLE -> ACCESS -> RESP -> IDLE and returns a one-cycle ack
//   on the granted port, with registered read data for reads.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pN_req/we/addr/wdata     request from port N, held stable until pN_ack
//   pN_ack                   one-cycle completion pulse for port N
//   pN_rdata                 last read data returned to port N
//   mem_read/mem_write       memory strobes, asserted only in ACCESS
//   mem_address/write_data   memory address/data, zero outside ACCESS
//   mem_read_data            combinational read data from memory
//   busy                     high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int AW          = 13,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 0,
  parameter int RR          = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_reg, state_next;
  logic          gnt_id_reg;      // 0 = port 0 owns the access, 1 = port 1
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [3:0]    wait_cnt_reg;
  logic          last_grant_reg;
  logic [DW-1:0] p0_rdata_reg, p1_rdata_reg;

  logic any_req;
  logic win_id;
  logic access_last;             // final ACCESS cycle: next edge enters RESP

  assign any_req     = p0_req | p1_req;
  assign access_last = (state_reg == ACCESS) && (wait_cnt_reg == 4'd0);

  // On a tie, round-robin hands the grant to the port not served last;
  // fixed priority always picks port 0. A lone request always wins.
  always_comb begin
    if (p0_req && p1_req)
      win_id = (RR != 0) ? ~last_grant_reg : 1'b0;
    else
      win_id = p1_req;
  end

  // Next-state and output decode. All mem_* outputs come from registers only,
  // so there is no combinational path from any req to the memory interface.
  always_comb begin
    state_next     = state_reg;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    p0_ack         = 1'b0;
    p1_ack         = 1'b0;
    busy           = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (any_req)
          state_next = ACCESS;
      end
      ACCESS: begin
        mem_address    = addr_reg;
        mem_write_data = wdata_reg;
        mem_read       = ~we_reg;
        // Write strobe only in the last cycle so the memory sees one write edge.
        mem_write      = we_reg & (wait_cnt_reg == 4'd0);
        if (wait_cnt_reg == 4'd0)
          state_next = RESP;
      end
      RESP: begin
        p0_ack     = ~gnt_id_reg;
        p1_ack     = gnt_id_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_id_reg     <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wait_cnt_reg   <= 4'd0;
      last_grant_reg <= 1'b1;   // so port 0 wins the first tie
      p0_rdata_reg   <= '0;
      p1_rdata_reg   <= '0;
    end else begin
      if (state_reg == IDLE && any_req) begin
        gnt_id_reg     <= win_id;
        last_grant_reg <= win_id;
        we_reg         <= win_id ? p1_we    : p0_we;
        addr_reg       <= win_id ? p1_addr  : p0_addr;
        wdata_reg      <= win_id ? p1_wdata : p0_wdata;
        wait_cnt_reg   <= 4'(WAIT_STATES);
      end
      if (state_reg == ACCESS && wait_cnt_reg != 4'd0)
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      // Read data is captured on the same edge that leaves ACCESS; writes
      // leave the port's rdata untouched.
      if (access_last && !we_reg) begin
        if (gnt_id_reg)
          p1_rdata_reg <= mem_read_data;
        else
          p0_rdata_reg <= mem_read_data;
      end
    end
  end

  assign p0_rdata = p0_rdata_reg;
  assign p1_rdata = p1_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Three instances share clk/rst:
//   inst 0: WAIT_STATES=0, RR=1   inst 1: WAIT_STATES=2, RR=0
//   inst 2: WAIT_STATES=3, RR=1
// Each instance has its own memory model (combinational read, write on edge).
module tb_mem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int NI = 3;

  logic          clk;
  logic          rst;
  logic          p0_req [NI];
  logic          p0_we  [NI];
  logic [AW-1:0] p0_addr[NI];
  logic [DW-1:0] p0_wdata[NI];
  logic          p0_ack [NI];
  logic [DW-1:0] p0_rdata[NI];
  logic          p1_req [NI];
  logic          p1_we  [NI];
  logic [AW-1:0] p1_addr[NI];
  logic [DW-1:0] p1_wdata[NI];
  logic          p1_ack [NI];
  logic [DW-1:0] p1_rdata[NI];
  logic          mem_read [NI];
  logic          mem_write[NI];
  logic [AW-1:0] mem_address[NI];
  logic [DW-1:0] mem_write_data[NI];
  logic [DW-1:0] mem_read_data[NI];
  logic          busy[NI];

  logic [DW-1:0] mem [NI][8192];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      mem_port_arbiter #(
        .AW(AW), .DW(DW),
        .WAIT_STATES((gi == 0) ? 0 : (gi == 1) ? 2 : 3),
        .RR((gi == 1) ? 0 : 1)
      ) u_dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[gi]), .p0_we(p0_we[gi]), .p0_addr(p0_addr[gi]),
        .p0_wdata(p0_wdata[gi]), .p0_ack(p0_ack[gi]), .p0_rdata(p0_rdata[gi]),
        .p1_req(p1_req[gi]), .p1_we(p1_we[gi]), .p1_addr(p1_addr[gi]),
        .p1_wdata(p1_wdata[gi]), .p1_ack(p1_ack[gi]), .p1_rdata(p1_rdata[gi]),
        .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
        .mem_address(mem_address[gi]), .mem_write_data(mem_write_data[gi]),
        .mem_read_data(mem_read_data[gi]), .busy(busy[gi])
      );
      assign mem_read_data[gi] = mem[gi][mem_address[gi]];
    end
  endgenerate

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      if (mem_write[k]) mem[k][mem_address[k]] <= mem_write_data[k];
  end

  // Drives one request on instance k / port p, waits for its ack (bounded),
  // then drops req and lets the FSM return to IDLE. lat counts samples taken
  // 1 time unit after each edge, starting with the grant edge as 1.
  task automatic run_access(input int k, input int p, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            output int lat, output int rd_cyc, output int wr_cyc,
                            output int other_ack, output logic [AW-1:0] addr_seen);
    lat = -1; rd_cyc = 0; wr_cyc = 0; other_ack = 0; addr_seen = '0;
    if (p == 0) begin
      p0_req[k] = 1'b1; p0_we[k] = we; p0_addr[k] = addr; p0_wdata[k] = wdata;
    end else begin
      p1_req[k] = 1'b1; p1_we[k] = we; p1_addr[k] = addr; p1_wdata[k] = wdata;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) addr_seen = mem_address[k];
      if (mem_read[k])  rd_cyc++;
      if (mem_write[k]) wr_cyc++;
      if ((p == 0) ? p1_ack[k] : p0_ack[k]) other_ack++;
      if ((p == 0) ? p0_ack[k] : p1_ack[k]) begin
        lat = c;
        break;
      end
    end
    if (p == 0) p0_req[k] = 1'b0; else p1_req[k] = 1'b0;
    $display("txn inst=%0d port=%0d we=%0b addr=%0d wdata=%h lat=%0d rd_cyc=%0d wr_cyc=%0d",
             k, p, we, addr, wdata, lat, rd_cyc, wr_cyc);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({busy[k], mem_read[k], mem_write[k], p0_ack[k], p1_ack[k]} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_ctrl inst=%0d: got busy/rd/wr/ack0/ack1=%b, expected 00000", k,
                 {busy[k], mem_read[k], mem_write[k], p0_ack[k], p1_ack[k]});
      end
      n_vec++;
      if ({mem_address[k], mem_write_data[k], p0_rdata[k], p1_rdata[k]} !== '0) begin
        n_err++;
        $display("FAIL reset_data inst=%0d: got addr=%h wd=%h r0=%h r1=%h, expected all 0", k,
                 mem_address[k], mem_write_data[k], p0_rdata[k], p1_rdata[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (busy[k] !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset inst=%0d: got busy=%b, expected 0", k, busy[k]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int acks;
    p1_req[1] = 1'b1; p1_we[1] = 1'b1; p1_addr[1] = 13'd600; p1_wdata[1] = 16'h00AA;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (mem_write[1] !== 1'b1) begin
      n_err++;
      $display("FAIL midacc_write_strobe: got mem_write=%b, expected 1", mem_write[1]);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_write[1], mem_read[1], busy[1]} !== 3'b000) begin
      n_err++;
      $display("FAIL midacc_abort: got wr/rd/busy=%b, expected 000",
               {mem_write[1], mem_read[1], busy[1]});
    end
    p1_req[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn inst=1 port=1 write 600 aborted by reset");
    n_vec++;
    if (mem[1][600] !== 16'h5555) begin
      n_err++;
      $display("FAIL midacc_mem_unchanged: got mem[600]=%h, expected 5555", mem[1][600]);
    end
    n_vec++;
    if (busy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL midacc_idle: got busy=%b, expected 0", busy[1]);
    end
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (p0_ack[1] || p1_ack[1]) acks++;
    end
    n_vec++;
    if (acks !== 0) begin
      n_err++;
      $display("FAIL midacc_no_ack: got %0d acks, expected 0", acks);
    end
  endtask

  task automatic test_single_read();
    int lat, rdc, wrc, oth;
    logic [AW-1:0] a;
    run_access(0, 0, 1'b0, 13'd500, 16'h0, lat, rdc, wrc, oth, a);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL read_latency: got %0d, expected 2", lat); end
    n_vec++;
    if (p0_rdata[0] !== 16'd2) begin n_err++; $display("FAIL read_data: got %h, expected 0002", p0_rdata[0]); end
    n_vec++;
    if (rdc !== 1) begin n_err++; $display("FAIL read_strobe_len: got %0d, expected 1", rdc); end
    n_vec++;
    if (oth !== 0 || wrc !== 0) begin n_err++; $display("FAIL read_side_effects: got p1_ack=%0d wr=%0d, expected 0/0", oth, wrc); end
    n_vec++;
    if (a !== 13'd500) begin n_err++; $display("FAIL read_address: got %0d, expected 500", a); end
  endtask

  task automatic test_write_then_read();
    int lat, rdc, wrc, oth;
    logic [AW-1:0] a;
    run_access(0, 1, 1'b0, 13'd506, 16'h0, lat, rdc, wrc, oth, a);
    n_vec++;
    if (p1_rdata[0] !== 16'd3) begin n_err++; $display("FAIL wr_pre_read: got %h, expected 0003", p1_rdata[0]); end
    run_access(0, 1, 1'b1, 13'd800, 16'h1234, lat, rdc, wrc, oth, a);
    n_vec++;
    if (wrc !== 1 || rdc !== 0) begin n_err++; $display("FAIL write_strobes: got wr=%0d rd=%0d, expected 1/0", wrc, rdc); end
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL write_latency: got %0d, expected 2", lat); end
    n_vec++;
    if (p1_rdata[0] !== 16'd3) begin n_err++; $display("FAIL write_keeps_rdata: got %h, expected 0003", p1_rdata[0]); end
    n_vec++;
    if (mem[0][800] !== 16'h1234) begin n_err++; $display("FAIL write_mem: got %h, expected 1234", mem[0][800]); end
    run_access(0, 1, 1'b0, 13'd800, 16'h0, lat, rdc, wrc, oth, a);
    n_vec++;
    if (p1_rdata[0] !== 16'h1234) begin n_err++; $display("FAIL readback: got %h, expected 1234", p1_rdata[0]); end
  endtask

  task automatic test_contention_rr();
    int ack_c[4];
    int ack_p[4];
    int n;
    int exp_c[4] = '{2, 5, 8, 11};
    int exp_p[4] = '{0, 1, 0, 1};
    pulse_reset();
    n = 0;
    p0_req[0] = 1'b1; p0_we[0] = 1'b0; p0_addr[0] = 13'd500;
    p1_req[0] = 1'b1; p1_we[0] = 1'b0; p1_addr[0] = 13'd506;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (p0_ack[0] || p1_ack[0]) begin
        ack_c[n] = c;
        ack_p[n] = p1_ack[0] ? 1 : 0;
        $display("txn inst=0 rr ack port=%0d cycle=%0d", ack_p[n], c);
        n++;
      end
    end
    p0_req[0] = 1'b0; p1_req[0] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (n !== 4) begin n_err++; $display("FAIL rr_ack_count: got %0d, expected 4", n); end
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (ack_p[i] !== exp_p[i] || ack_c[i] !== exp_c[i]) begin
        n_err++;
        $display("FAIL rr_grant_%0d: got port=%0d cycle=%0d, expected port=%0d cycle=%0d",
                 i, ack_p[i], ack_c[i], exp_p[i], exp_c[i]);
      end
    end
    n_vec++;
    if (p0_rdata[0] !== 16'd2 || p1_rdata[0] !== 16'd3) begin
      n_err++;
      $display("FAIL rr_rdata: got %h/%h, expected 0002/0003", p0_rdata[0], p1_rdata[0]);
    end
  endtask

  task automatic test_contention_fixed();
    int p0_c[3];
    int n0, p1_c;
    int exp0[3] = '{4, 9, 14};
    n0 = 0; p1_c = -1;
    p0_req[1] = 1'b1; p0_we[1] = 1'b0; p0_addr[1] = 13'd500;
    p1_req[1] = 1'b1; p1_we[1] = 1'b0; p1_addr[1] = 13'd506;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (p1_ack[1]) begin
        p1_c = c;
        $display("txn inst=1 fixed ack port=1 cycle=%0d", c);
        break;
      end
      if (p0_ack[1]) begin
        if (n0 < 3) p0_c[n0] = c;
        $display("txn inst=1 fixed ack port=0 cycle=%0d", c);
        n0++;
        if (n0 == 3) p0_req[1] = 1'b0;
      end
    end
    p0_req[1] = 1'b0; p1_req[1] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (n0 !== 3) begin n_err++; $display("FAIL fixed_p0_count: got %0d, expected 3", n0); end
    for (int i = 0; i < 3 && i < n0; i++) begin
      n_vec++;
      if (p0_c[i] !== exp0[i]) begin
        n_err++;
        $display("FAIL fixed_p0_ack_%0d: got cycle %0d, expected %0d", i, p0_c[i], exp0[i]);
      end
    end
    n_vec++;
    if (p1_c !== 19) begin n_err++; $display("FAIL fixed_p1_after_drop: got cycle %0d, expected 19", p1_c); end
    n_vec++;
    if (p1_rdata[1] !== 16'd3) begin n_err++; $display("FAIL fixed_p1_rdata: got %h, expected 0003", p1_rdata[1]); end
  endtask

  task automatic test_wait_states();
    int lat, rdc, wrc, oth;
    logic [AW-1:0] a;
    run_access(2, 0, 1'b0, 13'd506, 16'h0, lat, rdc, wrc, oth, a);
    n_vec++;
    if (lat !== 5) begin n_err++; $display("FAIL ws3_latency: got %0d, expected 5", lat); end
    n_vec++;
    if (rdc !== 4) begin n_err++; $display("FAIL ws3_read_len: got %0d, expected 4", rdc); end
    n_vec++;
    if (wrc !== 0) begin n_err++; $display("FAIL ws3_no_write: got %0d, expected 0", wrc); end
    n_vec++;
    if (p0_rdata[2] !== 16'd3) begin n_err++; $display("FAIL ws3_rdata: got %h, expected 0003", p0_rdata[2]); end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      p0_req[k] = 1'b0; p0_we[k] = 1'b0; p0_addr[k] = '0; p0_wdata[k] = '0;
      p1_req[k] = 1'b0; p1_we[k] = 1'b0; p1_addr[k] = '0; p1_wdata[k] = '0;
      for (int a = 0; a < 8192; a++) mem[k][a] = '0;
      mem[k][500] = 16'd2;
      mem[k][506] = 16'd3;
      mem[k][600] = 16'h5555;
    end
    test_reset();
    test_reset_mid_access();
    test_single_read();
    test_write_then_read();
    test_contention_rr();
    test_contention_fixed();
    test_wait_states();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
